// File: rtl/coef_serializer_pkg.sv
// Shared FIR coefficient-load defaults, serializer state encoding and word type.
package coef_serializer_pkg;

  localparam int NR_STAGES_DEF = 32;
  localparam int DWIDTH_DEF    = 16;
  localparam int CWIDTH_DEF    = NR_STAGES_DEF * DWIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bit 0 is the coefficient MSB.
  typedef logic [0:DWIDTH_DEF-1] coef_word_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/coef_serializer.sv
// Pulls NR_STAGES words over req/ack and shifts them LSB-first onto h/h_enabled.
// First bit two cycles after start; a one-word prefetch hides ack latency when the source keeps up.
module coef_serializer
  import coef_serializer_pkg::*;
#(
  parameter int NR_STAGES = NR_STAGES_DEF,
  parameter int DWIDTH    = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              coef_req,
  input  logic              coef_ack,
  input  logic [0:DWIDTH-1] coef_data,
  output logic              h,
  output logic              h_enabled,
  output logic              busy,
  output logic              done
);

  localparam int BW = cnt_width(DWIDTH);
  localparam int RW = cnt_width(NR_STAGES + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DWIDTH - 1);
  localparam logic [RW-1:0] REQ_ALL  = RW'(NR_STAGES);

  typedef logic [0:DWIDTH-1] word_t;

  state_t        state, state_nx;
  word_t         act_q, buf_q;
  logic          buf_full;
  logic [BW-1:0] bit_cnt;
  logic [RW-1:0] req_cnt;
  logic          xfer;
  logic          last_bit;

  assign xfer     = coef_req & coef_ack;
  assign last_bit = (bit_cnt == BIT_LAST);

  always_comb begin
    state_nx  = state;
    coef_req  = 1'b0;
    h_enabled = 1'b0;
    h         = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = FETCH;
      end
      FETCH: begin
        coef_req = 1'b1;
        busy     = 1'b1;
        if (xfer) state_nx = SHIFT;
      end
      SHIFT: begin
        busy      = 1'b1;
        h_enabled = 1'b1;
        h         = act_q[DWIDTH-1];
        coef_req  = !buf_full && (req_cnt != REQ_ALL);
        // A word arriving on the last bit goes straight to the active register.
        if (last_bit && !buf_full && !xfer)
          state_nx = (req_cnt == REQ_ALL) ? DONE : FETCH;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      act_q    <= '0;
      buf_q    <= '0;
      buf_full <= 1'b0;
      bit_cnt  <= '0;
      req_cnt  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          bit_cnt  <= '0;
          req_cnt  <= '0;
          buf_full <= 1'b0;
        end
        FETCH: begin
          if (xfer) begin
            act_q   <= coef_data;
            bit_cnt <= '0;
            req_cnt <= req_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (xfer) req_cnt <= req_cnt + 1'b1;
          if (last_bit) begin
            bit_cnt <= '0;
            if (buf_full) begin
              act_q    <= buf_q;
              buf_full <= 1'b0;
            end else if (xfer) begin
              act_q <= coef_data;
            end else begin
              act_q <= act_q >> 1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            act_q   <= act_q >> 1;
            if (xfer) begin
              buf_q    <= coef_data;
              buf_full <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
